// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 opcode/funct constants and multiply/divide FSM states.
package riscv_pkg;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;
    localparam logic [2:0] MD_MUL     = 3'b000;
    localparam logic [2:0] MD_MULH    = 3'b001;
    localparam logic [2:0] MD_MULHSU  = 3'b010;
    localparam logic [2:0] MD_MULHU   = 3'b011;
    localparam logic [2:0] MD_DIV     = 3'b100;
    localparam logic [2:0] MD_DIVU    = 3'b101;
    localparam logic [2:0] MD_REM     = 3'b110;
    localparam logic [2:0] MD_REMU    = 3'b111;
    typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: one-bit-per-cycle shift-add multiply / restoring divide iteration.
// Ports: load_i latches lo_i into acc[XLEN-1:0] and m_i as addend/divisor; step_i
// advances one iteration; acc_nxt_o is the value acc takes on the next step.
module muldiv_datapath #(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              div_i,
    input  logic [XLEN-1:0]   lo_i,
    input  logic [XLEN-1:0]   m_i,
    output logic [2*XLEN-1:0] acc_nxt_o
);
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   m;
    logic              div_q;
    logic [XLEN:0]     sum, shl;
    // Multiply: add m into the upper half when the multiplier LSB is set, then shift right
    // keeping the carry. Divide: shift left, the XLEN+1-bit partial remainder is compared
    // against the divisor so the bit shifted out is never lost.
    always_comb begin
        sum       = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, m & {XLEN{acc[0]}}};
        shl       = acc[2*XLEN-1:XLEN-1];
        acc_nxt_o = div_q ? ((shl >= {1'b0, m}) ? {XLEN'(shl - {1'b0, m}), acc[XLEN-2:0], 1'b1}
                                                : {shl[XLEN-1:0], acc[XLEN-2:0], 1'b0})
                          : {sum, acc[XLEN-1:1]};
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc   <= '0;
            m     <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            acc   <= {{XLEN{1'b0}}, lo_i};
            m     <= m_i;
            div_q <= div_i;
        end else if (step_i) begin
            acc   <= acc_nxt_o;
        end
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Ports: start_i/funct3_i/op_a_i/op_b_i/rd_i from ID/EX; flush_i aborts; stall_o holds
// the front end while busy; done_o pulses one cycle with result_o/rd_o valid.
import riscv_pkg::*;
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);
    md_state_t         state;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt;
    logic              is_div, sa, sb, neg, dbz, ovf, fast, go;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res, fin;
    logic [2*XLEN-1:0] acc_nxt, raw, cor;
    always_comb begin
        is_div   = funct3_i[2];
        // Operand signs only count for the signed variants; MULHSU treats op_b as unsigned.
        sa       = op_a_i[XLEN-1] & (is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11));
        sb       = op_b_i[XLEN-1] & (is_div ? ~funct3_i[0] : ~funct3_i[1]);
        neg      = (is_div & funct3_i[1]) ? sa : (sa ^ sb);
        mag_a    = sa ? -op_a_i : op_a_i;
        mag_b    = sb ? -op_b_i : op_b_i;
        dbz      = is_div & (op_b_i == '0);
        ovf      = is_div & ~funct3_i[0] & (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b_i);
        fast     = dbz | ovf;
        fast_res = dbz ? (funct3_i[1] ? op_a_i : '1) : (funct3_i[1] ? '0 : op_a_i);
        go       = (state == IDLE) & start_i & ~flush_i;
        stall_o  = go | (state == RUN);
        raw      = f3_q[2] ? {{XLEN{1'b0}}, f3_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0]}
                           : acc_nxt;
        cor      = neg_q ? -raw : raw;
        fin      = (f3_q[2] | (f3_q[1:0] == 2'b00)) ? cor[XLEN-1:0] : cor[2*XLEN-1:XLEN];
    end
    muldiv_datapath #(.XLEN(XLEN)) u_dp (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (go),
        .step_i    (state == RUN),
        .div_i     (is_div),
        .lo_i      (is_div ? mag_a : mag_b),
        .m_i       (is_div ? mag_b : mag_a),
        .acc_nxt_o (acc_nxt)
    );
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            cnt      <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
            rd_o     <= '0;
        end else if (flush_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        f3_q  <= funct3_i;
                        rd_q  <= rd_i;
                        neg_q <= neg;
                        cnt   <= CNT_W'(XLEN);
                        state <= fast ? DONE : RUN;
                        if (fast) begin
                            done_o   <= 1'b1;
                            result_o <= fast_res;
                            rd_o     <= rd_i;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state    <= DONE;
                        done_o   <= 1'b1;
                        result_o <= fin;
                        rd_o     <= rd_q;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: scoreboard bench for the RV32M iterative multiply/divide unit.
module tb_ex_muldiv_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic [4:0]  rd_i = '0;
    logic        stall_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    int          vectors = 0;
    int          miscompares = 0;

    typedef struct packed {logic [31:0] res; logic [4:0] rd;} exp_t;
    exp_t sb[$];

    ex_muldiv_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .start_i(start_i),
        .funct3_i(funct3_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_i(rd_i),
        .stall_o(stall_o), .done_o(done_o), .result_o(result_o), .rd_o(rd_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: p = a * b;
            3'd1: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            3'd2: p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
            3'd3: p = {32'b0, a} * {32'b0, b};
            default: p = '0;
        endcase
        case (f)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op at the next negedge (cycle T) and wait for done_o; lat is cycles from T.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] exp_res,
                          output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int stalls);
        @(negedge clk_i);
        start_i = 1'b1; funct3_i = f; op_a_i = a; op_b_i = b; rd_i = r;
        sb.push_back('{exp_res, r});
        lat = 0; stalls = 0;
        forever begin
            #1;
            if (stall_o) stalls++;
            if (done_o) break;
            if (lat > 100) begin
                vectors++; miscompares++;
                $display("FAIL timeout f3=%0d: no done_o within %0d cycles", f, lat);
                break;
            end
            @(negedge clk_i);
            lat++;
        end
        res = result_o; rdo = rd_o; start_i = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if ({stall_o, done_o, result_o, rd_o} !== 39'd0) begin
            miscompares++;
            $display("FAIL reset: stall=%b done=%b res=%h rd=%0d want all 0", stall_o, done_o, result_o, rd_o);
        end
        @(negedge clk_i); @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_mul;
        logic [31:0] res; logic [4:0] rdo; int lat, st; exp_t e;
        run_op(3'd0, 32'h7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, res, rdo, lat, st);
        e = sb.pop_front();
        vectors += 4;
        if (res !== e.res) begin miscompares++; $display("FAIL mul_res got %h want %h", res, e.res); end
        if (rdo !== e.rd) begin miscompares++; $display("FAIL mul_rd got %0d want %0d", rdo, e.rd); end
        if (lat != 33) begin miscompares++; $display("FAIL mul_latency got %0d want 33", lat); end
        if (st != 33) begin miscompares++; $display("FAIL mul_stall_cycles got %0d want 33", st); end
    endtask

    task automatic test_mulh;
        logic [2:0]  f3[3]  = '{3'd1, 3'd2, 3'd3};
        logic [31:0] exv[3] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        logic [31:0] res; logic [4:0] rdo; int lat, st; exp_t e;
        for (int i = 0; i < 3; i++) begin
            run_op(f3[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(10 + i), exv[i], res, rdo, lat, st);
            e = sb.pop_front();
            vectors++;
            if (res !== e.res || rdo !== e.rd)
                begin miscompares++; $display("FAIL mulh f3=%0d got %h/%0d want %h/%0d", f3[i], res, rdo, e.res, e.rd); end
        end
    endtask

    task automatic test_div;
        logic [2:0]  f3[4]  = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] av[4]  = '{-32'sd20, -32'sd20, 32'd100, 32'd100};
        logic [31:0] bv[4]  = '{32'd6, 32'd6, 32'd7, 32'd7};
        logic [31:0] exv[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd14, 32'd2};
        logic [31:0] res; logic [4:0] rdo; int lat, st; exp_t e;
        for (int i = 0; i < 4; i++) begin
            run_op(f3[i], av[i], bv[i], 5'(20 + i), exv[i], res, rdo, lat, st);
            e = sb.pop_front();
            vectors += 2;
            if (res !== e.res) begin miscompares++; $display("FAIL div f3=%0d got %h want %h", f3[i], res, e.res); end
            if (lat != 33) begin miscompares++; $display("FAIL div_latency f3=%0d got %0d want 33", f3[i], lat); end
        end
    endtask

    task automatic test_fast;
        logic [2:0]  f3[4]  = '{3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] av[4]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv[4]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exv[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        logic [31:0] res; logic [4:0] rdo; int lat, st; exp_t e;
        for (int i = 0; i < 4; i++) begin
            run_op(f3[i], av[i], bv[i], 5'(1 + i), exv[i], res, rdo, lat, st);
            e = sb.pop_front();
            vectors += 3;
            if (res !== e.res || rdo !== e.rd)
                begin miscompares++; $display("FAIL fast f3=%0d got %h/%0d want %h/%0d", f3[i], res, rdo, e.res, e.rd); end
            if (lat != 1) begin miscompares++; $display("FAIL fast_latency f3=%0d got %0d want 1", f3[i], lat); end
            if (st != 1) begin miscompares++; $display("FAIL fast_stall f3=%0d got %0d want 1", f3[i], st); end
        end
    endtask

    task automatic test_flush;
        logic [31:0] prev, res; logic [4:0] rdo, prev_rd; int lat, st; exp_t e;
        prev = result_o; prev_rd = rd_o;
        @(negedge clk_i);
        start_i = 1'b1; funct3_i = 3'd4; op_a_i = 32'd1000; op_b_i = 32'd3; rd_i = 5'd9;
        repeat (10) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; start_i = 1'b0;
        #1;
        vectors += 2;
        if (stall_o !== 1'b0 || done_o !== 1'b0)
            begin miscompares++; $display("FAIL flush_idle stall=%b done=%b want 0/0", stall_o, done_o); end
        if (result_o !== prev || rd_o !== prev_rd)
            begin miscompares++; $display("FAIL flush_hold got %h/%0d want %h/%0d", result_o, rd_o, prev, prev_rd); end
        run_op(3'd4, 32'd1000, 32'd3, 5'd9, 32'd333, res, rdo, lat, st);
        e = sb.pop_front();
        vectors += 2;
        if (res !== e.res || rdo !== e.rd)
            begin miscompares++; $display("FAIL flush_restart got %h/%0d want %h/%0d", res, rdo, e.res, e.rd); end
        if (lat != 33) begin miscompares++; $display("FAIL flush_restart_latency got %0d want 33", lat); end
    endtask

    task automatic test_start_flush;
        logic [31:0] prev; int seen;
        prev = result_o; seen = 0;
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd77; op_b_i = 32'd5; rd_i = 5'd3;
        #1;
        vectors++;
        if (stall_o !== 1'b0) begin miscompares++; $display("FAIL start_flush_stall got %b want 0", stall_o); end
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        repeat (40) begin @(negedge clk_i); #1; if (done_o) seen++; end
        vectors += 2;
        if (seen != 0) begin miscompares++; $display("FAIL start_flush_done got %0d pulses want 0", seen); end
        if (result_o !== prev) begin miscompares++; $display("FAIL start_flush_hold got %h want %h", result_o, prev); end
    endtask

    task automatic test_random;
        logic [2:0] f; logic [31:0] a, b, res; logic [4:0] rdo; int lat, st; exp_t e;
        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if (i % 3 == 0) b = b >> $urandom_range(0, 31);
            run_op(f, a, b, 5'($urandom), model(f, a, b), res, rdo, lat, st);
            e = sb.pop_front();
            vectors++;
            if (res !== e.res || rdo !== e.rd)
                begin miscompares++; $display("FAIL random f3=%0d a=%h b=%h got %h/%0d want %h/%0d", f, a, b, res, rdo, e.res, e.rd); end
        end
    endtask

    task automatic test_async_reset;
        int seen;
        seen = 0;
        @(negedge clk_i);
        start_i = 1'b1; funct3_i = 3'd0; op_a_i = 32'd12; op_b_i = 32'd13; rd_i = 5'd7;
        repeat (5) @(negedge clk_i);
        #1;
        rst_i = 1'b0; start_i = 1'b0;
        #1;
        vectors++;
        if ({stall_o, done_o, result_o, rd_o} !== 39'd0)
            begin miscompares++; $display("FAIL async_reset stall=%b done=%b res=%h rd=%0d want all 0", stall_o, done_o, result_o, rd_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (40) begin @(negedge clk_i); #1; if (done_o) seen++; end
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL async_reset_done got %0d pulses want 0", seen); end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_mulh;
        test_div;
        test_fast;
        test_flush;
        test_start_flush;
        test_random;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes operands, funct3 and rd from the ID/EX pipeline register.
- Stalls IF, ID and ID/EX while it computes, then presents one result for EX/MEM to latch.
- Shift-add multiply and restoring divide, one bit per cycle, with fast paths for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-low.
- flush_i  in  1  abort the current operation (branch mispredict / pipeline flush).
- start_i  in  1  M-extension op in EX (opcode 0110011, funct7 0000001); held by ID/EX while stalled.
- funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_i  in  XLEN  rs1 value, post-forwarding.
- op_b_i  in  XLEN  rs2 value, post-forwarding.
- rd_i  in  5  destination register.
- stall_o  out  1  hold PC, IF/ID and ID/EX; insert bubble into EX/MEM.
- done_o  out  1  result valid this cycle.
- result_o  out  XLEN  final result.
- rd_o  out  5  destination of the result.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset: state IDLE; done_o, result_o, rd_o and all datapath registers 0.
- stall_o is combinational: (IDLE & start_i & ~flush_i) | RUN. It is 0 in DONE so the pipeline advances and EX/MEM captures result_o.
- IDLE + start_i + ~flush_i:
  - Latch funct3, rd and operand magnitudes.
  - Record result sign: for MULH/DIV/REM per operand sign; for MULHSU op_a sign only; none for unsigned ops. REM sign follows the dividend.
  - Load counter with XLEN.
  - Go to RUN, unless a fast path applies.
- Fast paths (IDLE -> DONE directly, result ready one cycle after start):
  - DIV/DIVU with op_b=0: quotient all-ones.
  - REM/REMU with op_b=0: result = op_a.
  - DIV with op_a=0x80000000, op_b=0xFFFFFFFF: result 0x80000000.
  - REM with op_a=0x80000000, op_b=0xFFFFFFFF: result 0.
- RUN, one step per cycle, counter decrements; on the cycle the counter reaches 1 -> DONE.
  - Multiply: 2*XLEN-bit shift-add of the magnitudes.
  - Divide: restoring step on a 2*XLEN-bit remainder/quotient register.
- Final correction when entering DONE:
  - Negate (two's complement) if the result sign is set.
  - MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
  - DIV* return the quotient; REM* return the remainder.
- Latency: start seen at cycle T, RUN for T+1..T+XLEN, DONE at T+XLEN+1. stall_o is high for T..T+XLEN (XLEN+1 cycles).
- DONE: done_o=1 for exactly one cycle; result_o and rd_o valid. Unconditional -> IDLE. start_i is ignored in DONE because ID/EX still holds the same instruction.
- After DONE, result_o and rd_o hold their values until the next completion.
- start_i is ignored in RUN and DONE.
- flush_i in any state -> IDLE next edge. No done_o; result_o and rd_o are unchanged.
- flush_i and start_i together in IDLE: flush wins, and stall_o stays 0.
- Async reset mid-RUN: immediate return to IDLE with reset values; no done_o afterwards.
- Widths: all negation and selection is done in 2*XLEN bits; results are truncated to XLEN.

Decomposition:
- Shared package riscv_pkg holds:
  - OPC_RTYPE=7'b0110011 and F7_MULDIV=7'b0000001.
  - funct3 constants MD_MUL..MD_REMU.
  - enum md_state_t {IDLE, RUN, DONE}.
- One natural sub-module: muldiv_datapath, holding the shift-add/restoring iteration registers. The FSM, fast-path detection and sign correction stay in the top.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> stall_o high 33 cycles; done_o at T+33; result 0xFFFFFFEB; rd_o echoes rd_i=5.
- MULH / MULHSU / MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE.
- DIV -20 / 6 -> 0xFFFFFFFD; REM -20 / 6 -> 0xFFFFFFFE; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Fast paths:
  - DIV 5 / 0 -> 0xFFFFFFFF with done_o at T+1 and stall_o high only at T.
  - REMU 5 / 0 -> 5.
  - DIV 0x80000000 / -1 -> 0x80000000.
  - REM 0x80000000 / -1 -> 0.
- flush_i pulsed at T+10 of a DIV -> IDLE; no done_o; stall_o low from T+11. A new start at T+12 completes normally at T+45.
- rst_i low at T+5 of a MUL -> outputs 0 immediately. start_i and flush_i together in IDLE -> stall_o=0 and no operation starts.
